// File: rtl/mac_pkg.sv
// Shared RMII definitions for the MAC receive and transmit paths.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DRAIN    = 2'd3
  } rx_state_t;

  localparam logic [1:0] PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0] SFD_LAST_DIBIT  = 2'b11;
  localparam logic [1:0] RMII_IDLE_DIBIT = 2'b00;

endpackage

// File: rtl/rmii_clk_edge.sv
// Rising-edge detector for the RMII reference clock, which is sampled as data in clk.
module rmii_clk_edge (
  input  logic clk,
  input  logic rst,
  input  logic receive_clk,
  output logic tick
);

  logic r_last_receive_clk;

  always_ff @(posedge clk) begin
    if (rst) r_last_receive_clk <= 1'b0;
    else     r_last_receive_clk <= receive_clk;
  end

  assign tick = receive_clk & ~r_last_receive_clk;

endmodule

// File: rtl/mac_receive_byte.sv
// RMII receive deserializer: strips preamble/SFD and assembles dibits LSB-first into bytes.
// state    | meaning
// IDLE     | no carrier, or carrier with idle 00 dibits
// PREAMBLE | counting 01 dibits, waiting for the closing 11
// DATA     | assembling bytes, four dibits each
// DRAIN    | bad preamble or oversize frame; discard until carrier drops
module mac_receive_byte
  import mac_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MAX_FRAME_BYTES     = 1522,
  parameter int COUNT_WIDTH         = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   receive_clk,
  input  logic [1:0]             eth_rxd,
  input  logic                   eth_crsdv,
  output logic [7:0]             received_byte,
  output logic                   byte_valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   frame_error,
  output logic [COUNT_WIDTH-1:0] frame_byte_count
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_FRAME_BYTES);
  localparam logic [7:0]             MIN_PRE   = 8'(MIN_PREAMBLE_DIBITS);

  logic                   w_tick;
  rx_state_t              r_state;
  logic [7:0]             r_pre_count;
  logic [1:0]             r_dibit_count;
  logic [5:0]             r_shift;
  logic [7:0]             r_received_byte;
  logic                   r_byte_valid;
  logic                   r_frame_start;
  logic                   r_frame_end;
  logic                   r_frame_error;
  logic [COUNT_WIDTH-1:0] r_frame_byte_count;

  rmii_clk_edge u_edge (
    .clk         (clk),
    .rst         (rst),
    .receive_clk (receive_clk),
    .tick        (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= IDLE;
      r_pre_count        <= '0;
      r_dibit_count      <= '0;
      r_shift            <= '0;
      r_received_byte    <= '0;
      r_byte_valid       <= 1'b0;
      r_frame_start      <= 1'b0;
      r_frame_end        <= 1'b0;
      r_frame_error      <= 1'b0;
      r_frame_byte_count <= '0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (eth_crsdv) begin
              if (eth_rxd == PREAMBLE_DIBIT) begin
                r_state     <= PREAMBLE;
                r_pre_count <= 8'd1;
              end else if (eth_rxd != RMII_IDLE_DIBIT) begin
                r_state <= DRAIN;
              end
            end
          end
          PREAMBLE: begin
            if (!eth_crsdv) begin
              r_state <= IDLE;
            end else if (eth_rxd == PREAMBLE_DIBIT) begin
              if (r_pre_count != 8'hFF) r_pre_count <= r_pre_count + 8'd1;
            end else if (eth_rxd == SFD_LAST_DIBIT) begin
              if (r_pre_count >= MIN_PRE) begin
                r_state            <= DATA;
                r_frame_start      <= 1'b1;
                r_dibit_count      <= '0;
                r_frame_byte_count <= '0;
              end else begin
                r_state <= DRAIN;
              end
            end else if (eth_rxd != RMII_IDLE_DIBIT) begin
              r_state <= DRAIN;
            end
          end
          DATA: begin
            if (!eth_crsdv) begin
              // Carrier dropping mid-byte means the last byte is incomplete.
              if (r_dibit_count == 2'd0) r_frame_end   <= 1'b1;
              else                       r_frame_error <= 1'b1;
              r_dibit_count <= '0;
              r_state       <= IDLE;
            end else if (r_dibit_count == 2'd3) begin
              r_dibit_count <= '0;
              if (r_frame_byte_count == MAX_COUNT) begin
                r_frame_error <= 1'b1;
                r_state       <= DRAIN;
              end else begin
                r_received_byte    <= {eth_rxd, r_shift};
                r_byte_valid       <= 1'b1;
                r_frame_byte_count <= r_frame_byte_count + 1'b1;
              end
            end else begin
              r_shift[{r_dibit_count, 1'b0} +: 2] <= eth_rxd;
              r_dibit_count <= r_dibit_count + 2'd1;
            end
          end
          DRAIN: begin
            if (!eth_crsdv) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign received_byte    = r_received_byte;
  assign byte_valid       = r_byte_valid;
  assign frame_start      = r_frame_start;
  assign frame_end        = r_frame_end;
  assign frame_error      = r_frame_error;
  assign frame_byte_count = r_frame_byte_count;

endmodule
